// File: rtl/hazard_ctrl_pkg.sv
// Purpose : shared pipeline codes for the ID-stage hazard controller (md op codes, cp0 ops, md FSM states).
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package hazard_ctrl_pkg;

  localparam logic [1:0] MD_NONE  = 2'b00;
  localparam logic [1:0] MD_MULT  = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [2:0] CP0_MFC0 = 3'b001;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } md_state_e;

  // Code 2'b11 is reserved and behaves as "no multiply/divide".
  function automatic logic is_md_op(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Purpose : bundles the ID/EX hazard inputs and the pipeline control outputs of hazard_ctrl.
// Latency : n/a (wiring only).
// Backpressure: n/a; slave (hazard_ctrl) drives controls, master (pipeline) drives hazard info.
interface hazard_ctrl_if #(
  parameter int PERF_W = 16
);
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [1:0]        id_md_op;
  logic              id_rd_hilo;
  logic [4:0]        ex_rw;
  logic              ex_memRd;
  logic [2:0]        ex_cp0op;
  logic              ex_br_taken;
  logic              exc_flush;
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              idex_flush;
  logic              exmem_flush;
  logic              md_start;
  logic              md_busy;
  logic [PERF_W-1:0] perf_stall;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_md_op, id_rd_hilo,
           ex_rw, ex_memRd, ex_cp0op, ex_br_taken, exc_flush,
    input  pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush,
           md_start, md_busy, perf_stall
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_md_op, id_rd_hilo,
           ex_rw, ex_memRd, ex_cp0op, ex_br_taken, exc_flush,
    output pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush,
           md_start, md_busy, perf_stall
  );
endinterface

// File: rtl/hazard_ctrl_md_tracker.sv
// Purpose : tracks occupancy of the multi-cycle mult/div unit with a countdown FSM.
// Latency : busy rises the edge after start and stays high for LAT cycles; done marks the last one.
// Backpressure: none; caller must only pulse start while busy is low; abort wins over everything.
// Ports   : clk, rst_n | start, is_div, abort (in) | busy, done (out)
module md_tracker
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32,
  parameter int CNT_W    = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic is_div,
  input  logic abort,
  output logic busy,
  output logic done
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    if (abort) begin
      state_d  = RUN;
      md_cnt_d = '0;
    end else if (state_q == RUN) begin
      if (start) begin
        state_d  = MD_WAIT;
        md_cnt_d = is_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1);
      end
    end else begin
      if (md_cnt_q == '0) begin
        state_d = RUN;
      end else begin
        md_cnt_d = md_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  assign busy = (state_q == MD_WAIT);
  assign done = (state_q == MD_WAIT) && (md_cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Purpose : ID-stage hazard/stall controller: load-use, mfc0-use, HI/LO busy stalls plus branch/exception flushes.
// Latency : controls are combinational from current inputs and state; perf_stall updates one edge later.
// Backpressure: stalls hold PC and IF/ID and inject an ID/EX bubble; flushes always override stalls.
// Ports   : clk, rst_n (plain) | hif (slave modport: ID/EX hazard info in, pipeline controls out)
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32,
  parameter int CNT_W    = 6,
  parameter int PERF_W   = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  hazard_ctrl_if.slave   hif
);

  logic              dep_rs, dep_rt, lu_stall, md_stall, stall;
  logic              md_busy_w, md_done_w;
  logic              pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, md_start;
  logic [PERF_W-1:0] perf_stall_q, perf_stall_d;

  // $zero never carries a real dependence.
  assign dep_rs   = hif.id_use_rs && (hif.id_rs != 5'd0) && (hif.id_rs == hif.ex_rw);
  assign dep_rt   = hif.id_use_rt && (hif.id_rt != 5'd0) && (hif.id_rt == hif.ex_rw);
  assign lu_stall = (hif.ex_memRd || (hif.ex_cp0op == CP0_MFC0)) && (dep_rs || dep_rt);
  // The done cycle is part of busy: HI/LO results land at the end of it, so readers wait one more edge.
  assign md_stall = (md_busy_w || md_done_w) && (hif.id_rd_hilo || is_md_op(hif.id_md_op));
  assign stall    = lu_stall || md_stall;

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    md_start    = 1'b0;
    if (hif.exc_flush) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (hif.ex_br_taken) begin
      // A mult/div sitting in ID is being squashed, so it must not start.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end else begin
      md_start = is_md_op(hif.id_md_op) && !md_busy_w;
    end
  end

  md_tracker #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) u_md_tracker (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .is_div (hif.id_md_op == MD_DIV),
    .abort  (hif.exc_flush),
    .busy   (md_busy_w),
    .done   (md_done_w)
  );

  always_comb begin
    perf_stall_d = perf_stall_q;
    if (!pc_write && (perf_stall_q != '1)) begin
      perf_stall_d = perf_stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
    end
  end

  assign hif.pc_write    = pc_write;
  assign hif.ifid_write  = ifid_write;
  assign hif.ifid_flush  = ifid_flush;
  assign hif.idex_flush  = idex_flush;
  assign hif.exmem_flush = exmem_flush;
  assign hif.md_start    = md_start;
  assign hif.md_busy     = md_busy_w;
  assign hif.perf_stall  = perf_stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   perf_exp;

  hazard_ctrl_if #(.PERF_W(16)) hif ();

  hazard_ctrl #(
    .MULT_LAT (4),
    .DIV_LAT  (32),
    .CNT_W    (6),
    .PERF_W   (16)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hif   (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic [1:0] md_op;
    logic       rd_hilo;
    logic [4:0] ex_rw;
    logic       mem_rd;
    logic [2:0] cp0op;
    logic       br;
    logic       exc;
    logic [5:0] exp;   // {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, md_start}
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [5:0] ctrl_bits();
    return {hif.pc_write, hif.ifid_write, hif.ifid_flush, hif.idex_flush,
            hif.exmem_flush, hif.md_start};
  endfunction

  task automatic clear_inputs();
    hif.id_rs = '0; hif.id_rt = '0; hif.id_use_rs = 0; hif.id_use_rt = 0;
    hif.id_md_op = 2'b00; hif.id_rd_hilo = 0; hif.ex_rw = '0; hif.ex_memRd = 0;
    hif.ex_cp0op = 3'b000; hif.ex_br_taken = 0; hif.exc_flush = 0;
  endtask

  // Advance one edge and settle away from it; inputs are driven after this returns.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apply(input vec_t v);
    hif.id_rs = v.rs; hif.id_rt = v.rt; hif.id_use_rs = v.use_rs; hif.id_use_rt = v.use_rt;
    hif.id_md_op = v.md_op; hif.id_rd_hilo = v.rd_hilo; hif.ex_rw = v.ex_rw;
    hif.ex_memRd = v.mem_rd; hif.ex_cp0op = v.cp0op; hif.ex_br_taken = v.br;
    hif.exc_flush = v.exc;
  endtask

  initial begin
    int stalls;
    int busys;
    n_tests  = 0;
    n_fail   = 0;
    perf_exp = 0;
    clear_inputs();

    //            rs  rt  urs urt md     hilo exrw mrd cp0     br exc  expected
    vecs[0]  = '{5'd0, 5'd0, 0, 0, 2'b00, 0, 5'd0, 0, 3'b000, 0, 0, 6'b110000}; // idle
    vecs[1]  = '{5'd5, 5'd0, 1, 0, 2'b00, 0, 5'd5, 1, 3'b000, 0, 0, 6'b000100}; // load-use rs
    vecs[2]  = '{5'd0, 5'd7, 0, 1, 2'b00, 0, 5'd7, 1, 3'b000, 0, 0, 6'b000100}; // load-use rt
    vecs[3]  = '{5'd0, 5'd0, 1, 0, 2'b00, 0, 5'd0, 1, 3'b000, 0, 0, 6'b110000}; // $zero
    vecs[4]  = '{5'd5, 5'd0, 0, 0, 2'b00, 0, 5'd5, 1, 3'b000, 0, 0, 6'b110000}; // rs not used
    vecs[5]  = '{5'd0, 5'd9, 0, 1, 2'b00, 0, 5'd9, 0, 3'b001, 0, 0, 6'b000100}; // mfc0-use
    vecs[6]  = '{5'd0, 5'd9, 0, 1, 2'b00, 0, 5'd9, 0, 3'b010, 0, 0, 6'b110000}; // other cp0 op
    vecs[7]  = '{5'd3, 5'd0, 1, 0, 2'b00, 0, 5'd3, 0, 3'b000, 0, 0, 6'b110000}; // alu dep: forwarded
    vecs[8]  = '{5'd5, 5'd0, 1, 0, 2'b00, 0, 5'd5, 1, 3'b000, 1, 0, 6'b111100}; // branch + load-use
    vecs[9]  = '{5'd5, 5'd0, 1, 0, 2'b00, 0, 5'd5, 1, 3'b000, 0, 1, 6'b111110}; // exc + load-use
    vecs[10] = '{5'd0, 5'd0, 0, 0, 2'b00, 0, 5'd0, 0, 3'b000, 1, 1, 6'b111110}; // exc over branch
    vecs[11] = '{5'd0, 5'd0, 0, 0, 2'b01, 0, 5'd0, 0, 3'b000, 1, 0, 6'b111100}; // mult squashed by br
    vecs[12] = '{5'd0, 5'd0, 0, 0, 2'b10, 0, 5'd0, 0, 3'b000, 0, 1, 6'b111110}; // div squashed by exc
    vecs[13] = '{5'd0, 5'd0, 0, 0, 2'b11, 0, 5'd0, 0, 3'b000, 0, 0, 6'b110000}; // reserved md op
    vecs[14] = '{5'd4, 5'd0, 1, 0, 2'b01, 0, 5'd4, 1, 3'b000, 0, 0, 6'b000100}; // mult held by load-use
    vecs[15] = '{5'd0, 5'd0, 0, 0, 2'b00, 1, 5'd0, 0, 3'b000, 0, 0, 6'b110000}; // mflo, unit idle

    // Reset state.
    rst_n = 1'b0;
    #12;
    check("rst_ctrl", 32'(ctrl_bits()), 32'(6'b110000));
    check("rst_busy", 32'(hif.md_busy), 32'd0);
    check("rst_perf", 32'(hif.perf_stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Table-driven single-cycle decode in RUN state.
    for (int i = 0; i < 16; i++) begin
      apply(vecs[i]);
      #1;
      check($sformatf("vec%0d_ctrl", i), 32'(ctrl_bits()), 32'(vecs[i].exp));
      check($sformatf("vec%0d_perf", i), 32'(hif.perf_stall), 32'(perf_exp));
      if (vecs[i].exp[5] == 1'b0) perf_exp++;
      tick();
    end
    clear_inputs();
    #1;
    check("tbl_busy", 32'(hif.md_busy), 32'd0);
    check("tbl_perf", 32'(hif.perf_stall), 32'(perf_exp));

    // Load-use: one stall, then the bubble in EX lets ID proceed.
    hif.id_rs = 5'd5; hif.id_use_rs = 1; hif.ex_rw = 5'd5; hif.ex_memRd = 1;
    #1;
    check("lu_pcw", 32'(hif.pc_write), 32'd0);
    check("lu_idex_flush", 32'(hif.idex_flush), 32'd1);
    tick();
    perf_exp++;
    hif.ex_rw = 5'd0; hif.ex_memRd = 0;
    #1;
    check("lu_next_pcw", 32'(hif.pc_write), 32'd1);
    check("lu_perf", 32'(hif.perf_stall), 32'(perf_exp));
    tick();
    clear_inputs();

    // mult then mflo: mflo stalls exactly MULT_LAT cycles.
    hif.id_md_op = 2'b01;
    #1;
    check("mult_start", 32'(hif.md_start), 32'd1);
    check("mult_busy0", 32'(hif.md_busy), 32'd0);
    tick();
    hif.id_md_op = 2'b00; hif.id_rd_hilo = 1;
    #1;
    stalls = 0; busys = 0;
    while (hif.pc_write == 1'b0 && stalls < 20) begin
      stalls++;
      if (hif.md_busy) busys++;
      tick();
      #1;
    end
    perf_exp += stalls;
    check("mflo_stall_cycles", 32'(stalls), 32'd4);
    check("mult_busy_cycles", 32'(busys), 32'd4);
    check("mflo_pass_busy", 32'(hif.md_busy), 32'd0);
    check("mflo_perf", 32'(hif.perf_stall), 32'(perf_exp));
    tick();
    clear_inputs();

    // div at cycle 0, independent adds on cycles 1..9, second div at cycle 10.
    hif.id_md_op = 2'b10;
    #1;
    check("div1_start", 32'(hif.md_start), 32'd1);
    tick();
    hif.id_md_op = 2'b00; hif.id_rs = 5'd3; hif.id_use_rs = 1; hif.ex_rw = 5'd4;
    stalls = 0;
    for (int c = 1; c < 10; c++) begin
      #1;
      if (hif.pc_write == 1'b0) stalls++;
      tick();
    end
    check("add_stalls", 32'(stalls), 32'd0);
    hif.id_md_op = 2'b10; hif.id_use_rs = 0;
    #1;
    stalls = 0;
    while (hif.pc_write == 1'b0 && stalls < 60) begin
      stalls++;
      tick();
      #1;
    end
    perf_exp += stalls;
    check("div2_stall_cycles", 32'(stalls), 32'd23);
    check("div2_start", 32'(hif.md_start), 32'd1);
    tick();
    clear_inputs();
    // Second div is now in MD_WAIT with count 31; walk down to 20 then take an exception.
    for (int c = 0; c < 11; c++) tick();
    #1;
    check("exc_pre_busy", 32'(hif.md_busy), 32'd1);
    hif.exc_flush = 1;
    #1;
    check("exc_ctrl", 32'(ctrl_bits()), 32'(6'b111110));
    tick();
    hif.exc_flush = 0;
    #1;
    check("exc_post_busy", 32'(hif.md_busy), 32'd0);
    check("exc_perf", 32'(hif.perf_stall), 32'(perf_exp));

    // Async reset in the middle of MD_WAIT.
    tick();
    hif.id_md_op = 2'b10;
    tick();
    hif.id_md_op = 2'b00;
    tick();
    #1;
    check("ar_pre_busy", 32'(hif.md_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("ar_busy", 32'(hif.md_busy), 32'd0);
    check("ar_perf", 32'(hif.perf_stall), 32'd0);
    // Exception held across reset release: reset dominates, nothing counts.
    hif.exc_flush = 1;
    tick();
    tick();
    #1;
    check("ar_hold_busy", 32'(hif.md_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    hif.exc_flush = 0;
    #1;
    check("ar_rel_perf", 32'(hif.perf_stall), 32'd0);
    check("ar_rel_ctrl", 32'(ctrl_bits()), 32'(6'b110000));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
